data_cache_controller: RTL and testbench

//  Responder side of the MEM-stage memory interface: accepts READ_WRITE/ADDRESS/WRITEDATA from the EX/MEM pipeline register outputs and drives BUSYWAIT back to all pipeline registers.

---
 rtl/data_cache_controller.sv | 166 ++++++++++++++++
 tb/tb_data_cache_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Hits complete combinationally with no stall. A miss stalls the pipeline
// through BUSYWAIT while a dirty victim is written back and the line is refilled.
module data_cache_controller #(
  parameter int INDEX_BITS = 3
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [3:0]   READ_WRITE,
  input  logic [31:0]  ADDRESS,
  input  logic [31:0]  WRITEDATA,
  output logic [31:0]  READDATA,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic         MEM_WRITE,
  output logic [27:0]  MEM_ADDRESS,
  output logic [127:0] MEM_WRITEDATA,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 28 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

  state_t state_reg, state_next;

  // Tag and data arrays carry no reset; only valid/dirty are cleared.
  logic [TAG_BITS-1:0] tag_reg  [LINES];
  logic [127:0]        data_reg [LINES];
  logic [LINES-1:0]    valid_reg;
  logic [LINES-1:0]    dirty_reg;

  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   addr_tag;
  logic [1:0]            size;
  logic                  access;
  logic                  is_write;
  logic                  hit;
  logic                  victim_dirty;
  logic                  hit_write;
  logic [31:0]           line_word;
  logic [31:0]           load_data;
  logic [31:0]           store_data;
  logic [31:0]           merged_word;
  logic [3:0]            lane_we;

  assign index        = ADDRESS[3+INDEX_BITS:4];
  assign addr_tag     = ADDRESS[31:4+INDEX_BITS];
  assign size         = READ_WRITE[1:0];
  assign access       = READ_WRITE[3];
  assign is_write     = READ_WRITE[2];
  assign hit          = valid_reg[index] && (tag_reg[index] == addr_tag);
  assign victim_dirty = valid_reg[index] && dirty_reg[index];
  assign hit_write    = (state_reg == IDLE) && access && hit && is_write;
  assign line_word    = data_reg[index][{ADDRESS[3:2], 5'b00000} +: 32];

  // Extract the addressed byte/half/word and zero-extend it; reserved size acts as word.
  always_comb begin
    load_data = line_word;
    case (size)
      2'b00:   load_data = {24'h0, line_word[{ADDRESS[1:0], 3'b000} +: 8]};
      2'b01:   load_data = {16'h0, line_word[{ADDRESS[1], 4'b0000} +: 16]};
      default: load_data = line_word;
    endcase
  end

  // Replicate store data across lanes so each enabled lane picks up the right bits.
  always_comb begin
    store_data = WRITEDATA;
    case (size)
      2'b00:   store_data = {4{WRITEDATA[7:0]}};
      2'b01:   store_data = {2{WRITEDATA[15:0]}};
      default: store_data = WRITEDATA;
    endcase
  end

  // Per-byte-lane write enable and merge of store data into the current word.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign lane_we[gi] = (size == 2'b00) ? (ADDRESS[1:0] == LANE) :
                           (size == 2'b01) ? (ADDRESS[1] == LANE[1]) : 1'b1;
      assign merged_word[8*gi +: 8] = lane_we[gi] ? store_data[8*gi +: 8]
                                                  : line_word[8*gi +: 8];
    end
  endgenerate

  // State register plus valid/dirty bookkeeping, cleared asynchronously.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg <= IDLE;
      valid_reg <= '0;
      dirty_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == UPDATE) begin
        valid_reg[index] <= 1'b1;
        dirty_reg[index] <= 1'b0;
      end else if (hit_write) begin
        dirty_reg[index] <= 1'b1;
      end
    end
  end

  // Array writes: refill on fetch completion, tag on update, store merge on write hit.
  // While RESET is high the FSM sits in IDLE with no valid lines, so nothing here fires.
  always_ff @(posedge CLK) begin
    if (state_reg == FETCH && !MEM_BUSYWAIT) begin
      data_reg[index] <= MEM_READDATA;
    end else if (hit_write) begin
      data_reg[index][{ADDRESS[3:2], 5'b00000} +: 32] <= merged_word;
    end
    if (state_reg == UPDATE) begin
      tag_reg[index] <= addr_tag;
    end
  end

  // Next-state logic and all outputs; outputs are forced quiet while RESET is high.
  always_comb begin
    state_next    = state_reg;
    BUSYWAIT      = 1'b0;
    READDATA      = 32'h0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = 28'h0;
    MEM_WRITEDATA = 128'h0;
    case (state_reg)
      IDLE: begin
        if (access) begin
          if (hit) begin
            if (!is_write) READDATA = load_data;
          end else begin
            BUSYWAIT   = 1'b1;
            state_next = victim_dirty ? WRITEBACK : FETCH;
          end
        end
      end
      WRITEBACK: begin
        BUSYWAIT      = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_reg[index], index};
        MEM_WRITEDATA = data_reg[index];
        if (!MEM_BUSYWAIT) state_next = FETCH;
      end
      FETCH: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = ADDRESS[31:4];
        if (!MEM_BUSYWAIT) state_next = UPDATE;
      end
      UPDATE: begin
        BUSYWAIT   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (RESET) begin
      BUSYWAIT = 1'b0;
      READDATA = 32'h0;
    end
  end

endmodule

// File: tb/tb_data_cache_controller.sv
// Self-checking bench for data_cache_controller: a flat byte-array view of
// memory plus a line-residency table predict load data, stall lengths and
// write-back traffic; a 5-cycle block memory model sits behind the cache.
module tb_data_cache_controller;

  localparam int MEM_LAT   = 5;
  localparam int BUSY_CAP  = 4 * MEM_LAT + 20;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [3:0]   READ_WRITE;
  logic [31:0]  ADDRESS;
  logic [31:0]  WRITEDATA;
  logic [31:0]  READDATA;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  data_cache_controller #(.INDEX_BITS(3)) dut (
    .CLK(CLK), .RESET(RESET), .READ_WRITE(READ_WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Backing memory (blocks 0..31) and the architectural byte view (addresses 0..511).
  logic [127:0] dram [32];
  logic [7:0]   arch [512];
  bit           res_valid [8];
  bit           res_dirty [8];
  logic [1:0]   res_tag   [8];
  logic [27:0]  exp_victim_blk = 28'h0;
  int           vectors = 0;
  int           miscompares = 0;
  int           mem_cnt = 0;
  int           txn_no = 0;

  function automatic logic [127:0] init_block(int blk);
    logic [127:0] r;
    for (int w = 0; w < 4; w++)
      r[w*32 +: 32] = (32'(blk) * 32'h0100_0193) ^ (32'(w) * 32'h1111_1111) ^ 32'hC0DE_0000;
    return r;
  endfunction

  function automatic logic [127:0] arch_block(int blk);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = arch[blk*16 + i];
    return r;
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] addr, logic [1:0] size);
    int a;
    a = int'(addr[8:0]);
    case (size)
      2'b00:   return {24'h0, arch[a]};
      2'b01:   begin a = a & ~1; return {16'h0, arch[a+1], arch[a]}; end
      default: begin a = a & ~3; return {arch[a+3], arch[a+2], arch[a+1], arch[a]}; end
    endcase
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] d);
    int a;
    a = int'(addr[8:0]);
    case (size)
      2'b00: arch[a] = d[7:0];
      2'b01: begin a = a & ~1; arch[a] = d[7:0]; arch[a+1] = d[15:8]; end
      default: begin
        a = a & ~3;
        for (int i = 0; i < 4; i++) arch[a+i] = d[i*8 +: 8];
      end
    endcase
  endtask

  // A reset throws away cached (possibly dirty) data: memory becomes the truth again.
  task automatic model_reset();
    for (int a = 0; a < 512; a++) arch[a] = dram[a/16][(a%16)*8 +: 8];
    for (int i = 0; i < 8; i++) begin
      res_valid[i] = 1'b0;
      res_dirty[i] = 1'b0;
      res_tag[i]   = 2'b00;
    end
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Block memory: each request completes in its MEM_LAT-th cycle.
  always @(posedge CLK) begin
    if (RESET || !(MEM_READ || MEM_WRITE)) begin
      mem_cnt <= 0;
    end else if (!MEM_BUSYWAIT) begin
      mem_cnt <= 0;
      if (MEM_WRITE) dram[MEM_ADDRESS[4:0]] <= MEM_WRITEDATA;
    end else begin
      mem_cnt <= mem_cnt + 1;
    end
  end
  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mem_cnt < MEM_LAT - 1);
  assign MEM_READDATA = dram[MEM_ADDRESS[4:0]];

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge CLK) begin
    if (RESET) begin
      check("rst_busywait", 128'(BUSYWAIT), 128'(0));
      check("rst_readdata", 128'(READDATA), 128'(0));
      check("rst_mem_req", 128'({MEM_READ, MEM_WRITE}), 128'(0));
      check("rst_mem_address", 128'(MEM_ADDRESS), 128'(0));
      check("rst_mem_writedata", MEM_WRITEDATA, 128'(0));
    end else begin
      check("rd_wr_exclusive", 128'(MEM_READ & MEM_WRITE), 128'(0));
      if (MEM_READ) check("fetch_addr", 128'(MEM_ADDRESS), 128'(ADDRESS[31:4]));
      if (MEM_WRITE) begin
        check("wb_addr", 128'(MEM_ADDRESS), 128'(exp_victim_blk));
        check("wb_data", MEM_WRITEDATA, arch_block(int'(exp_victim_blk[4:0])));
      end
      if (!READ_WRITE[3]) begin
        check("idle_busywait", 128'(BUSYWAIT), 128'(0));
        check("idle_readdata", 128'(READDATA), 128'(0));
        check("idle_mem_req", 128'({MEM_READ, MEM_WRITE}), 128'(0));
      end else if (!READ_WRITE[2] && !BUSYWAIT) begin
        check("load_data", 128'(READDATA), 128'(model_read(ADDRESS, READ_WRITE[1:0])));
      end
    end
  end

  // One access from IDLE to completion; called just after a rising edge.
  task automatic access(input logic [3:0] rw, input logic [31:0] addr, input logic [31:0] wdata,
                        output int busy, output logic [31:0] rdata);
    int         idx;
    logic [1:0] tag;
    bit         hit, dirty_victim, saw_wr, saw_rd, done;
    int         exp_busy;
    idx          = int'(addr[6:4]);
    tag          = addr[8:7];
    hit          = res_valid[idx] && (res_tag[idx] == tag);
    dirty_victim = !hit && res_valid[idx] && res_dirty[idx];
    exp_busy     = (!rw[3] || hit) ? 0 : (dirty_victim ? 2*MEM_LAT + 2 : MEM_LAT + 2);
    exp_victim_blk = 28'({res_tag[idx], addr[6:4]});
    READ_WRITE = rw;
    ADDRESS    = addr;
    WRITEDATA  = wdata;
    busy = 0; saw_wr = 0; saw_rd = 0; done = 0;
    while (!done) begin
      @(negedge CLK);
      if (!BUSYWAIT) done = 1;
      else begin
        busy++;
        saw_wr |= MEM_WRITE;
        saw_rd |= MEM_READ;
        if (busy > BUSY_CAP) begin
          check("busy_timeout", 128'(1), 128'(0));
          done = 1;
        end
      end
    end
    rdata = READDATA;
    if (rw[3]) begin
      check("stall_cycles", 128'(busy), 128'(exp_busy));
      check("writeback_issued", 128'(saw_wr), 128'(dirty_victim));
      check("fetch_issued", 128'(saw_rd), 128'(!hit));
    end
    @(posedge CLK);
    if (rw[3]) begin
      if (rw[2]) model_write(addr, rw[1:0], wdata);
      res_valid[idx] = 1'b1;
      res_tag[idx]   = tag;
      if (!hit)  res_dirty[idx] = 1'b0;
      if (rw[2]) res_dirty[idx] = 1'b1;
    end
    txn_no++;
    $display("txn %0d rw=%b addr=%h wdata=%h stall=%0d rdata=%h", txn_no, rw, addr, wdata, busy, rdata);
    #1;
  endtask

  int          busy;
  logic [31:0] rdata;

  initial begin
    for (int b = 0; b < 32; b++) dram[b] = init_block(b);
    model_reset();

    // Reset with a stale request on the inputs.
    RESET = 1'b1; READ_WRITE = 4'b1010; ADDRESS = 32'h40; WRITEDATA = 32'h0;
    repeat (3) @(negedge CLK);
    READ_WRITE = 4'b0000;
    RESET = 1'b0;
    @(posedge CLK); #1;

    // Clean miss on 0x40, then a hit.
    access(4'b1010, 32'h40, 32'h0, busy, rdata);
    check("first_miss_stall", 128'(busy), 128'(7));
    check("first_miss_data", 128'(rdata), 128'(32'hC4DE_064C));
    access(4'b1010, 32'h40, 32'h0, busy, rdata);
    check("reread_stall", 128'(busy), 128'(0));

    // Byte store hit, then read back the merged word.
    access(4'b1100, 32'h41, 32'h0000_00AB, busy, rdata);
    check("byte_store_stall", 128'(busy), 128'(0));
    access(4'b1010, 32'h40, 32'h0, busy, rdata);
    check("merged_word", 128'(rdata), 128'(32'hC4DE_AB4C));

    // Dirty-victim miss at 0xC0 (same index).
    access(4'b1010, 32'hC0, 32'h0, busy, rdata);
    check("dirty_miss_stall", 128'(busy), 128'(12));
    check("dirty_miss_data", 128'(rdata), 128'(32'hCCDE_12E4));
    check("writeback_landed", 128'(dram[4][31:0]), 128'(32'hC4DE_AB4C));

    // Reset in the middle of a fetch.
    exp_victim_blk = 28'h0;
    READ_WRITE = 4'b1010; ADDRESS = 32'h140;
    for (int i = 0; i < 20 && !MEM_READ; i++) @(negedge CLK);
    check("fetch_started", 128'(MEM_READ), 128'(1));
    #1 RESET = 1'b1;
    #1;
    check("midfetch_rst_mem_read", 128'(MEM_READ), 128'(0));
    check("midfetch_rst_busywait", 128'(BUSYWAIT), 128'(0));
    READ_WRITE = 4'b0000;
    @(posedge CLK);
    @(negedge CLK);
    model_reset();
    RESET = 1'b0;
    @(posedge CLK); #1;
    access(4'b1010, 32'h140, 32'h0, busy, rdata);
    check("post_rst_miss_stall", 128'(busy), 128'(7));
    check("post_rst_miss_data", 128'(rdata), 128'(32'hD4DE_1F7C));

    // No-access cycles with random addresses.
    for (int i = 0; i < 10; i++) access(4'b0000, $urandom, $urandom, busy, rdata);

    // Randomized mix of loads, stores, sizes and conflicting addresses.
    for (int i = 0; i < 200; i++) begin
      logic [3:0] rw;
      rw = {($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
      access(rw, 32'($urandom_range(0, 511)), $urandom, busy, rdata);
    end

    READ_WRITE = 4'b0000;
    @(posedge CLK); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
